// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl
// Bridges 32-bit pipeline loads/stores onto a 16-bit asynchronous SRAM.
// Each word is transferred as two halfword accesses (LOW then HIGH), and
// each access is held for SRAM_WAIT clock cycles. The pipeline is stalled
// through ready while a transfer is in flight.
// The SRAM_* pin outputs are registered and are decoded from the next state,
// so they change exactly on the clock edge that enters the state they belong to.
// Legal SRAM_WAIT range is 1..15 because the wait counter is 4 bits wide.
module mem_sram_ctrl #(
    parameter int unsigned SRAM_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_WE_N
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter value reached on the last cycle of a halfword access.
    localparam logic [3:0]  C_CNT_LAST  = 4'(SRAM_WAIT - 32'd1);
    // Data memory starts at byte address 1024 in the processor map.
    localparam logic [31:0] C_BASE_ADDR = 32'd1024;

    // State and latched request.
    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_addr;
    logic [31:0] w_addr_nxt;
    logic [31:0] r_wdata;
    logic [31:0] w_wdata_nxt;
    logic        r_op_wr;
    logic        w_op_wr_nxt;
    logic [31:0] r_rd_data;
    logic [31:0] w_rd_data_nxt;

    // Registered SRAM pins and their next values.
    logic [17:0] r_sram_addr;
    logic [17:0] w_sram_addr_nxt;
    logic [15:0] r_dq_out;
    logic [15:0] w_dq_out_nxt;
    logic        r_dq_oe;
    logic        w_dq_oe_nxt;
    logic        r_we_n;
    logic        w_we_n_nxt;

    // Helpers.
    logic        w_req;
    logic        w_cnt_last;
    logic        w_ready;
    logic [31:0] w_addr_off;
    logic [16:0] w_word;
    logic        w_unused_addr_bits;

    assign w_req      = wr_en | rd_en;
    assign w_cnt_last = (r_cnt == C_CNT_LAST);

    // Word index relative to the data base, modulo 2^32. Only 17 word bits
    // reach the 18-bit halfword bus; higher bits and the byte offset alias.
    assign w_addr_off = w_addr_nxt - C_BASE_ADDR;
    assign w_word     = w_addr_off[18:2];
    assign w_unused_addr_bits = ^{w_addr_off[31:19], w_addr_off[1:0]};

    assign rd_data     = r_rd_data;
    assign ready       = w_ready;
    assign SRAM_ADDR   = r_sram_addr;
    assign SRAM_DQ_out = r_dq_out;
    assign SRAM_DQ_oe  = r_dq_oe;
    assign SRAM_WE_N   = r_we_n;

    // Next-state, request latching, read capture and combinational stall.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_op_wr_nxt   = r_op_wr;
        w_rd_data_nxt = r_rd_data;
        w_ready       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = ~w_req;
                if (w_req) begin
                    // Store wins when both requests are raised together.
                    w_addr_nxt  = address;
                    w_wdata_nxt = wr_data;
                    w_op_wr_nxt = wr_en;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_LOW;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (w_cnt_last) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_HIGH;
                    if (!r_op_wr) begin
                        w_rd_data_nxt[15:0] = SRAM_DQ_in;
                    end else begin
                        w_rd_data_nxt = r_rd_data;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_HIGH: begin
                if (w_cnt_last) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_DONE;
                    if (!r_op_wr) begin
                        w_rd_data_nxt[31:16] = SRAM_DQ_in;
                    end else begin
                        w_rd_data_nxt = r_rd_data;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_DONE: begin
                w_ready     = 1'b1;
                w_cnt_nxt   = 4'd0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_ready     = 1'b0;
                w_cnt_nxt   = 4'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // SRAM pin values for the state being entered on the next edge.
    always_comb begin
        w_sram_addr_nxt = 18'd0;
        w_dq_out_nxt    = 16'd0;
        w_dq_oe_nxt     = 1'b0;
        w_we_n_nxt      = 1'b1;
        case (w_state_nxt)
            ST_LOW: begin
                w_sram_addr_nxt = {w_word, 1'b0};
                if (w_op_wr_nxt) begin
                    w_dq_out_nxt = w_wdata_nxt[15:0];
                    w_dq_oe_nxt  = 1'b1;
                    w_we_n_nxt   = 1'b0;
                end else begin
                    w_dq_out_nxt = 16'd0;
                    w_dq_oe_nxt  = 1'b0;
                    w_we_n_nxt   = 1'b1;
                end
            end
            ST_HIGH: begin
                w_sram_addr_nxt = {w_word, 1'b1};
                if (w_op_wr_nxt) begin
                    w_dq_out_nxt = w_wdata_nxt[31:16];
                    w_dq_oe_nxt  = 1'b1;
                    w_we_n_nxt   = 1'b0;
                end else begin
                    w_dq_out_nxt = 16'd0;
                    w_dq_oe_nxt  = 1'b0;
                    w_we_n_nxt   = 1'b1;
                end
            end
            default: begin
                w_sram_addr_nxt = 18'd0;
                w_dq_out_nxt    = 16'd0;
                w_dq_oe_nxt     = 1'b0;
                w_we_n_nxt      = 1'b1;
            end
        endcase
    end

    // State register, latched request and read data; reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_op_wr   <= 1'b0;
            r_rd_data <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_op_wr   <= w_op_wr_nxt;
            r_rd_data <= w_rd_data_nxt;
        end
    end

    // Registered SRAM pins; reset parks the bus with no strobe and no drive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sram_addr <= 18'd0;
            r_dq_out    <= 16'd0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
        end else begin
            r_sram_addr <= w_sram_addr_nxt;
            r_dq_out    <= w_dq_out_nxt;
            r_dq_oe     <= w_dq_oe_nxt;
            r_we_n      <= w_we_n_nxt;
        end
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl
// Two controllers (SRAM_WAIT=2 and SRAM_WAIT=1) share the stimulus; sel picks
// the one that is checked and that owns the SRAM model. Stimulus pushes the
// expected pin values for every cycle and the expected rd_data of every
// completed transfer; a negedge monitor pops and compares.
module tb_mem_sram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] wr_data;
    logic        sel;

    logic [31:0] rd_a,  rd_b;
    logic        rdy_a, rdy_b;
    logic [17:0] adr_a, adr_b;
    logic [15:0] dqo_a, dqo_b;
    logic        oe_a,  oe_b;
    logic        wen_a, wen_b;
    logic [15:0] dqi_a, dqi_b;

    mem_sram_ctrl #(.SRAM_WAIT(2)) u_dut_w2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .wr_data(wr_data), .rd_data(rd_a), .ready(rdy_a),
        .SRAM_ADDR(adr_a), .SRAM_DQ_out(dqo_a), .SRAM_DQ_oe(oe_a),
        .SRAM_DQ_in(dqi_a), .SRAM_WE_N(wen_a)
    );

    mem_sram_ctrl #(.SRAM_WAIT(1)) u_dut_w1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .wr_data(wr_data), .rd_data(rd_b), .ready(rdy_b),
        .SRAM_ADDR(adr_b), .SRAM_DQ_out(dqo_b), .SRAM_DQ_oe(oe_b),
        .SRAM_DQ_in(dqi_b), .SRAM_WE_N(wen_b)
    );

    // Selected controller's outputs.
    logic [31:0] m_rd;
    logic        m_ready;
    logic [17:0] m_addr;
    logic [15:0] m_dq;
    logic        m_oe;
    logic        m_we_n;

    always_comb begin
        if (sel) begin
            m_rd = rd_b; m_ready = rdy_b; m_addr = adr_b;
            m_dq = dqo_b; m_oe = oe_b; m_we_n = wen_b;
        end else begin
            m_rd = rd_a; m_ready = rdy_a; m_addr = adr_a;
            m_dq = dqo_a; m_oe = oe_a; m_we_n = wen_a;
        end
    end

    // SRAM model: sparse preload, written by the selected controller.
    bit [15:0] mem [1024];
    bit        wrf [1024];

    function automatic logic [9:0] midx(input logic [17:0] a);
        return {a[17], a[8:0]};
    endfunction

    function automatic logic [15:0] preload(input logic [17:0] a);
        case (a)
            18'd2:   return 16'h5678;
            18'd3:   return 16'h1234;
            18'd10:  return 16'hA55A;
            18'd11:  return 16'h0FF0;
            default: return 16'hE0E0;
        endcase
    endfunction

    always_comb begin
        dqi_a = wrf[midx(adr_a)] ? mem[midx(adr_a)] : preload(adr_a);
        dqi_b = wrf[midx(adr_b)] ? mem[midx(adr_b)] : preload(adr_b);
    end

    always @(posedge clk) begin
        if (m_we_n === 1'b0) begin
            mem[midx(m_addr)] <= m_dq;
            wrf[midx(m_addr)] <= 1'b1;
        end
    end

    // Scoreboard queues.
    typedef struct packed {
        logic        ready;
        logic        we_n;
        logic        oe;
        logic [17:0] addr;
        logic [15:0] dq;
        logic        chk_rd;
        logic [31:0] rd;
    } cyc_t;

    cyc_t        cyc_q[$];
    logic [31:0] done_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_rd = 32'd0;

    // Monitor: per-cycle pin check, plus rd_data at each completion (ready 0->1).
    initial begin
        cyc_t        c;
        logic [31:0] e;
        logic        prev_ready;
        prev_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                total++;
                if (m_ready !== c.ready || m_we_n !== c.we_n || m_oe !== c.oe ||
                    m_addr !== c.addr || m_dq !== c.dq || (c.chk_rd && m_rd !== c.rd)) begin
                    bad++;
                    $display("FAIL pins t=%0t: got ready=%b we_n=%b oe=%b addr=%h dq=%h rd=%h, want ready=%b we_n=%b oe=%b addr=%h dq=%h rd=%h(chk=%b)",
                             $time, m_ready, m_we_n, m_oe, m_addr, m_dq, m_rd,
                             c.ready, c.we_n, c.oe, c.addr, c.dq, c.rd, c.chk_rd);
                end
            end
            if (rst !== 1'b1) begin
                prev_ready = 1'b1;
            end else begin
                if (m_ready === 1'b1 && prev_ready === 1'b0) begin
                    total++;
                    if (done_q.size() == 0) begin
                        bad++;
                        $display("FAIL done t=%0t: unexpected completion, rd_data=%h", $time, m_rd);
                    end else begin
                        e = done_q.pop_front();
                        if (m_rd !== e) begin
                            bad++;
                            $display("FAIL rd_data t=%0t: got %h want %h", $time, m_rd, e);
                        end
                    end
                end
                prev_ready = m_ready;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cyc(input logic rdy, input logic we_n, input logic oe,
                            input logic [17:0] a, input logic [15:0] d,
                            input logic chk, input logic [31:0] rd);
        cyc_t c;
        c.ready = rdy; c.we_n = we_n; c.oe = oe; c.addr = a; c.dq = d;
        c.chk_rd = chk; c.rd = rd;
        cyc_q.push_back(c);
    endtask

    task automatic scramble();
        wr_en   = 1'($urandom_range(0, 1));
        rd_en   = 1'($urandom_range(0, 1));
        address = $urandom;
        wr_data = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            wr_en = 1'b0; rd_en = 1'b0;
            push_cyc(1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 1'b0, 32'd0);
        end
    endtask

    task automatic do_reset(input logic new_sel);
        step();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        sel = new_sel;
        step();
        rst = 1'b1;
        exp_rd = 32'd0;
        push_cyc(1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 1'b1, 32'd0);
    endtask

    // One full transfer; inputs are scrambled once the request is latched.
    task automatic run_txn(input logic we, input logic re, input logic [31:0] a,
                           input logic [31:0] d, input logic [17:0] lo,
                           input logic [31:0] rd_new, input int w);
        step();
        wr_en = we; rd_en = re; address = a; wr_data = d;
        push_cyc(1'b0, 1'b1, 1'b0, 18'd0, 16'd0, 1'b0, 32'd0);
        for (int k = 0; k < w; k++) begin
            step(); scramble();
            push_cyc(1'b0, ~we, we, lo, we ? d[15:0] : 16'd0, 1'b0, 32'd0);
        end
        for (int k = 0; k < w; k++) begin
            step(); scramble();
            push_cyc(1'b0, ~we, we, lo + 18'd1, we ? d[31:16] : 16'd0, 1'b0, 32'd0);
        end
        step(); scramble();
        push_cyc(1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 1'b0, 32'd0);
        if (!we) exp_rd = rd_new;
        done_q.push_back(exp_rd);
    endtask

    typedef struct packed {
        logic        we;
        logic        re;
        logic [31:0] a;
        logic [31:0] d;
        logic [17:0] lo;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[9];

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'h0,        18'd2,       32'h12345678};
        vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 18'd2,       32'h0};
        vecs[2] = '{1'b0, 1'b1, 32'd1028, 32'h0,        18'd2,       32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b1, 32'd1024, 32'hCAFEF00D, 18'd0,       32'h0};
        vecs[4] = '{1'b0, 1'b1, 32'd1044, 32'h0,        18'd10,      32'h0FF0A55A};
        vecs[5] = '{1'b1, 1'b0, 32'd0,    32'h01234567, 18'h3FE00,   32'h0};
        vecs[6] = '{1'b0, 1'b1, 32'd0,    32'h0,        18'h3FE00,   32'h01234567};
        vecs[7] = '{1'b0, 1'b1, 32'd1030, 32'h0,        18'd2,       32'hDEADBEEF};
        vecs[8] = '{1'b0, 1'b1, 32'd1024, 32'h0,        18'd0,       32'hCAFEF00D};

        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        address = 32'd0; wr_data = 32'd0; sel = 1'b0;

        do_reset(1'b0);
        idle(10);

        // Directed vectors, back-to-back, SRAM_WAIT=2.
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].d, vecs[i].lo, vecs[i].rd, 2);
        end
        idle(2);

        // Reset asserted in the first HIGH cycle of a write to 1048.
        step();
        wr_en = 1'b1; rd_en = 1'b0; address = 32'd1048; wr_data = 32'h55AA33CC;
        push_cyc(1'b0, 1'b1, 1'b0, 18'd0, 16'd0, 1'b0, 32'd0);
        for (int k = 0; k < 2; k++) begin
            step(); scramble();
            push_cyc(1'b0, 1'b0, 1'b1, 18'd12, 16'h33CC, 1'b0, 32'd0);
        end
        step(); scramble(); rst = 1'b0;
        push_cyc(1'b0, 1'b0, 1'b1, 18'd13, 16'h55AA, 1'b0, 32'd0);
        step();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        exp_rd = 32'd0;
        push_cyc(1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 1'b1, 32'd0);
        idle(3);
        run_txn(1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hDEADBEEF, 2);
        idle(2);

        // Back-to-back write then read, SRAM_WAIT=1.
        do_reset(1'b1);
        run_txn(1'b1, 1'b0, 32'd1052, 32'h89ABCDEF, 18'd14, 32'h0, 1);
        run_txn(1'b0, 1'b1, 32'd1052, 32'h0, 18'd14, 32'h89ABCDEF, 1);
        run_txn(1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hDEADBEEF, 1);
        idle(3);

        step();
        total++;
        if (cyc_q.size() != 0) begin
            bad++;
            $display("FAIL cyc_q drain: got %0d left want 0", cyc_q.size());
        end
        total++;
        if (done_q.size() != 0) begin
            bad++;
            $display("FAIL done_q drain: got %0d left want 0", done_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_sram_ctrl.md
MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

Interface
REQ-001 Parameter SRAM_WAIT, default 2, clock cycles spent on each 16-bit half access; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low (rst=0 resets on the next rising clk edge).
REQ-004 wr_en  input  1  store request from the EXE/MEM pipeline register (MEM_W_EN).
REQ-005 rd_en  input  1  load request from the EXE/MEM pipeline register (MEM_R_EN).
REQ-006 address  input  32  byte address, taken from ALU_result.
REQ-007 wr_data  input  32  store data, taken from ST_val.
REQ-008 rd_data  output  32  load result; valid in the DONE cycle and held until the next load completes.
REQ-009 ready  output  1  0 = stall; the top level drives pipeline freeze = ~ready.
REQ-010 SRAM_ADDR  output  18  SRAM halfword address.
REQ-011 SRAM_DQ_out  output  16  write data to the SRAM.
REQ-012 SRAM_DQ_oe  output  1  1 = drive SRAM_DQ_out onto the SRAM data bus.
REQ-013 SRAM_DQ_in  input  16  read data from the SRAM.
REQ-014 SRAM_WE_N  output  1  SRAM write strobe, active-low.

Function
REQ-015 FSM states: IDLE, LOW, HIGH, DONE.
REQ-016 IDLE: if wr_en|rd_en is 1, latch address, wr_data and op, clear the counter, and go to LOW; otherwise stay in IDLE.
  - op = write when wr_en=1; wr_en has priority if both are 1.
REQ-017 LOW: stay for exactly SRAM_WAIT cycles, then go to HIGH with the counter cleared.
REQ-018 HIGH: stay for exactly SRAM_WAIT cycles, then go to DONE.
REQ-019 DONE: lasts one cycle, then goes to IDLE unconditionally.
REQ-020 Latched request inputs are used for the whole transaction; deasserting or changing inputs after IDLE has no effect.
REQ-021 Address mapping: word = (address - 32'd1024) >> 2, computed modulo 2^32.
  - LOW: SRAM_ADDR = {word[16:0],1'b0}.
  - HIGH: SRAM_ADDR = {word[16:0],1'b1}.
  - IDLE and DONE: SRAM_ADDR = 0.
REQ-022 Write op:
  - LOW: SRAM_DQ_out = wr_data[15:0]; HIGH: SRAM_DQ_out = wr_data[31:16].
  - SRAM_WE_N = 0 and SRAM_DQ_oe = 1 throughout LOW and HIGH.
REQ-023 Read op:
  - SRAM_WE_N = 1 and SRAM_DQ_oe = 0 in all states.
  - rd_data[15:0] captures SRAM_DQ_in on the last LOW cycle.
  - rd_data[31:16] captures SRAM_DQ_in on the last HIGH cycle.
REQ-024 Outside LOW/HIGH of a write: SRAM_WE_N = 1, SRAM_DQ_oe = 0, SRAM_DQ_out = 0.
REQ-025 ready is combinational:
  - IDLE: ready = ~(wr_en|rd_en).
  - LOW, HIGH: ready = 0.
  - DONE: ready = 1.
REQ-026 Stall length: a request first seen in IDLE at cycle 0 gives ready=0 for cycles 0..2*SRAM_WAIT and ready=1 at cycle 2*SRAM_WAIT+1 (DONE).
REQ-027 Back-to-back requests: a request present in the cycle after DONE starts a new transaction from IDLE with no extra idle cycle.
REQ-028 rd_data is not modified by write transactions.

Reset
REQ-029 On rst=0 at a clock edge, regardless of the current state (including mid-transaction):
  - state = IDLE, counter = 0, rd_data = 0, latched address/data/op = 0.
  - outputs: SRAM_WE_N = 1, SRAM_DQ_oe = 0, SRAM_ADDR = 0, SRAM_DQ_out = 0.
REQ-030 An aborted transaction issues no further SRAM strobes; ready follows REQ-025 from IDLE on the first cycle after reset is released.

Verification
REQ-031 Idle: rst released, wr_en=rd_en=0 for 10 cycles -> ready=1, SRAM_WE_N=1, SRAM_DQ_oe=0 every cycle.
REQ-032 Write, SRAM_WAIT=2: wr_en=1, address=1028, wr_data=32'hDEADBEEF ->
  - cycles 1-2: SRAM_ADDR=2, DQ_out=16'hBEEF, WE_N=0.
  - cycles 3-4: SRAM_ADDR=3, DQ_out=16'hDEAD, WE_N=0.
  - ready=0 for cycles 0-4; ready=1 at cycle 5.
REQ-033 Read, SRAM_WAIT=2: rd_en=1, address=1028; SRAM model returns 16'h5678 at SRAM_ADDR=2 and 16'h1234 at SRAM_ADDR=3 -> rd_data=32'h12345678 at cycle 5, WE_N=1 throughout.
REQ-034 Both wr_en=1 and rd_en=1 at address=1024 -> write performed at SRAM_ADDR 0 then 1; rd_data unchanged.
REQ-035 Reset mid-write: rst=0 asserted during HIGH -> next cycle IDLE, WE_N=1, DQ_oe=0, rd_data=0; a new read issued after release completes normally.
REQ-036 Back-to-back, SRAM_WAIT=1: write then read held continuously -> ready pattern 0,0,0,1,0,0,0,1; input changes after IDLE are ignored.
